// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and access sequencer for the shared data memory.
// One access at a time through IDLE -> ACCESS -> DONE. The grant is combinational
// in IDLE/DONE. The command is latched at the grant edge. The memory bus is driven
// only in ACCESS. Completion (rvalid/rerr) is strobed in DONE.
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration. When it is left
// undefined, requester 0 has fixed priority.
// Ports:
//   clk, rst            clock, async active-high reset
//   req, we             per-requester request / store select
//   addr0/1, wdata0/1   byte address, right-aligned store data
//   size0/1, funct3_0/1 access size (00 B, 01 H, 10 W), load sign/zero select
//   gnt, rvalid         one-hot accept / completion strobes
//   rerr, rdata         error flag with rvalid, last load result
//   m_*                 memory-side command; m_rdata is combinational read data
module dmem_arbiter #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    req,
   input  logic [1:0]    we,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   input  logic [1:0]    size0,
   input  logic [1:0]    size1,
   input  logic [2:0]    funct3_0,
   input  logic [2:0]    funct3_1,
   output logic [1:0]    gnt,
   output logic [1:0]    rvalid,
   output logic          rerr,
   output logic [DW-1:0] rdata,
   output logic          m_wr_en,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   output logic [1:0]    m_store_size,
   output logic [1:0]    m_load_size,
   output logic [2:0]    m_funct3,
   input  logic [DW-1:0] m_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [1:0]    r_size;
   logic [2:0]    r_funct3;
   logic          r_win;
   logic          r_legal;
   logic [DW-1:0] r_rdata;

   logic          w_win;
   logic          w_take;
   logic          w_sel_we;
   logic [AW-1:0] w_sel_addr;
   logic [DW-1:0] w_sel_wdata;
   logic [1:0]    w_sel_size;
   logic [2:0]    w_sel_funct3;
   logic          w_sel_legal;

   // Winner selection
`ifdef DMEM_ARB_RR_EN
   logic r_last;

   // On a contest the requester that did not win last time goes first
   assign w_win = (req == 2'b11) ? ~r_last : req[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last <= 1'b1;
      end else if (w_take) begin
         r_last <= w_win;
      end
   end
`else
   assign w_win = ~req[0];
`endif

   // Command mux from the winning requester
   assign w_sel_we     = w_win ? we[1]    : we[0];
   assign w_sel_addr   = w_win ? addr1    : addr0;
   assign w_sel_wdata  = w_win ? wdata1   : wdata0;
   assign w_sel_size   = w_win ? size1    : size0;
   assign w_sel_funct3 = w_win ? funct3_1 : funct3_0;

   // Alignment / size legality of the selected command
   always_comb begin
      w_sel_legal = 1'b0;
      case (w_sel_size)
         2'b00:   w_sel_legal = 1'b1;
         2'b01:   w_sel_legal = ~w_sel_addr[0];
         2'b10:   w_sel_legal = (w_sel_addr[1:0] == 2'b00);
         default: w_sel_legal = 1'b0;
      endcase
   end

   // Next state, grant, completion and memory bus decode
   always_comb begin
      w_state_nxt  = r_state;
      w_take       = 1'b0;
      gnt          = 2'b00;
      rvalid       = 2'b00;
      rerr         = 1'b0;
      m_wr_en      = 1'b0;
      m_addr       = '0;
      m_wdata      = '0;
      m_store_size = 2'b00;
      m_load_size  = 2'b00;
      m_funct3     = 3'b000;
      case (r_state)
         S_ACCESS: begin
            // Reset pulls state to IDLE asynchronously; the rst term drops the
            // write enable in the same instant
            m_wr_en      = r_we & r_legal & ~rst;
            m_addr       = r_addr;
            m_wdata      = r_wdata;
            m_store_size = r_size;
            m_load_size  = r_size;
            m_funct3     = r_funct3;
            w_state_nxt  = S_DONE;
         end
         default: begin
            if (r_state == S_DONE) begin
               rvalid = r_win ? 2'b10 : 2'b01;
               rerr   = ~r_legal;
            end
            if ((req != 2'b00) && !rst) begin
               w_take      = 1'b1;
               gnt         = w_win ? 2'b10 : 2'b01;
               w_state_nxt = S_ACCESS;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
      endcase
   end

   // State, latched command and load result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_size   <= 2'b00;
         r_funct3 <= 3'b000;
         r_win    <= 1'b0;
         r_legal  <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_take) begin
            r_we     <= w_sel_we;
            r_addr   <= w_sel_addr;
            r_wdata  <= w_sel_wdata;
            r_size   <= w_sel_size;
            r_funct3 <= w_sel_funct3;
            r_win    <= w_win;
            r_legal  <= w_sel_legal;
         end
         if ((r_state == S_ACCESS) && !r_we && r_legal) begin
            r_rdata <= m_rdata;
         end
      end
   end

   assign rdata = r_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: table-driven single transactions against a small
// byte-addressed memory model, plus hand-written reset, contention and
// back-to-back sequences.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req, we;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic [1:0]  size0, size1;
   logic [2:0]  funct3_0, funct3_1;
   logic [1:0]  gnt, rvalid;
   logic        rerr;
   logic [31:0] rdata;
   logic        m_wr_en;
   logic [31:0] m_addr, m_wdata;
   logic [1:0]  m_store_size, m_load_size;
   logic [2:0]  m_funct3;
   logic [31:0] m_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.AW(32), .DW(32)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .size0(size0), .size1(size1), .funct3_0(funct3_0), .funct3_1(funct3_1),
      .gnt(gnt), .rvalid(rvalid), .rerr(rerr), .rdata(rdata),
      .m_wr_en(m_wr_en), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_store_size(m_store_size), .m_load_size(m_load_size),
      .m_funct3(m_funct3), .m_rdata(m_rdata)
   );

   // Little-endian byte memory; funct3[2] selects zero extension on loads
   logic [7:0] mem [0:255] = '{default: 8'h00};
   logic [7:0] mem_a;
   assign mem_a = m_addr[7:0];

   always_comb begin
      case (m_load_size)
         2'b00:   m_rdata = m_funct3[2] ? {24'h0, mem[mem_a]}
                                        : {{24{mem[mem_a][7]}}, mem[mem_a]};
         2'b01:   m_rdata = m_funct3[2] ? {16'h0, mem[mem_a + 8'd1], mem[mem_a]}
                                        : {{16{mem[mem_a + 8'd1][7]}}, mem[mem_a + 8'd1], mem[mem_a]};
         default: m_rdata = {mem[mem_a + 8'd3], mem[mem_a + 8'd2], mem[mem_a + 8'd1], mem[mem_a]};
      endcase
   end

   always @(posedge clk) begin
      if (m_wr_en) begin
         mem[mem_a] <= m_wdata[7:0];
         if (m_store_size != 2'b00) mem[mem_a + 8'd1] <= m_wdata[15:8];
         if (m_store_size == 2'b10) begin
            mem[mem_a + 8'd2] <= m_wdata[23:16];
            mem[mem_a + 8'd3] <= m_wdata[31:24];
         end
      end
   end

   typedef struct {
      logic        rq;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic [2:0]  f3;
      logic        exp_wr;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   localparam int unsigned NVEC = 15;
   vec_t vecs [NVEC];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   // Active requester gets the command; the other one carries junk so a wrong
   // mux select is visible on the memory bus
   task automatic drive(input logic rq, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] s, input logic [2:0] f);
      we       = rq ? {w, 1'b1} : {1'b1, w};
      addr0    = rq ? 32'hFFFF_FFFC : a;
      addr1    = rq ? a : 32'hFFFF_FFFC;
      wdata0   = rq ? 32'h5555_AAAA : d;
      wdata1   = rq ? d : 32'h5555_AAAA;
      size0    = rq ? 2'b11 : s;
      size1    = rq ? s : 2'b11;
      funct3_0 = rq ? 3'b111 : f;
      funct3_1 = rq ? f : 3'b111;
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      @(posedge clk); #1;
      drive(v.rq, v.we, v.addr, v.wdata, v.size, v.f3);
      req = v.rq ? 2'b10 : 2'b01;
      @(negedge clk);
      chk({tag, "_gnt"}, 32'(gnt), v.rq ? 32'd2 : 32'd1);
      chk({tag, "_idle_wr"}, 32'(m_wr_en), 32'd0);
      @(posedge clk); #1;
      req = 2'b00;
      @(negedge clk);
      chk({tag, "_wr_en"}, 32'(m_wr_en), 32'(v.exp_wr));
      chk({tag, "_addr"}, m_addr, v.addr);
      chk({tag, "_wdata"}, m_wdata, v.wdata);
      chk({tag, "_ssize"}, 32'(m_store_size), 32'(v.size));
      chk({tag, "_lsize"}, 32'(m_load_size), 32'(v.size));
      chk({tag, "_f3"}, 32'(m_funct3), 32'(v.f3));
      chk({tag, "_acc_rv"}, 32'(rvalid), 32'd0);
      @(negedge clk);
      chk({tag, "_rvalid"}, 32'(rvalid), v.rq ? 32'd2 : 32'd1);
      chk({tag, "_rerr"}, 32'(rerr), 32'(v.exp_err));
      chk({tag, "_rdata"}, rdata, v.exp_rdata);
      chk({tag, "_done_wr"}, 32'(m_wr_en), 32'd0);
      chk({tag, "_done_addr"}, m_addr, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   initial begin
      vec_t lv;
      int   n_g;
      int   cyc;
      logic [1:0] exp_g;
      logic [1:0] exp_rv;

      //          rq    we    addr          wdata          size   f3      wr    err   rdata
      vecs[0]  = '{1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 3'b010, 1'b1, 1'b0, 32'h0000_0000};
      vecs[1]  = '{1'b0, 1'b0, 32'h10, 32'h0,         2'b10, 3'b010, 1'b0, 1'b0, 32'hDEAD_BEEF};
      vecs[2]  = '{1'b0, 1'b1, 32'h13, 32'h0000_1234, 2'b01, 3'b001, 1'b0, 1'b1, 32'hDEAD_BEEF};
      vecs[3]  = '{1'b0, 1'b0, 32'h22, 32'h0,         2'b10, 3'b010, 1'b0, 1'b1, 32'hDEAD_BEEF};
      vecs[4]  = '{1'b0, 1'b0, 32'h10, 32'h0,         2'b10, 3'b010, 1'b0, 1'b0, 32'hDEAD_BEEF};
      vecs[5]  = '{1'b1, 1'b1, 32'h21, 32'h0000_0080, 2'b00, 3'b000, 1'b1, 1'b0, 32'hDEAD_BEEF};
      vecs[6]  = '{1'b1, 1'b0, 32'h21, 32'h0,         2'b00, 3'b100, 1'b0, 1'b0, 32'h0000_0080};
      vecs[7]  = '{1'b0, 1'b0, 32'h21, 32'h0,         2'b00, 3'b000, 1'b0, 1'b0, 32'hFFFF_FF80};
      vecs[8]  = '{1'b1, 1'b0, 32'h20, 32'h0,         2'b01, 3'b101, 1'b0, 1'b0, 32'h0000_8000};
      vecs[9]  = '{1'b1, 1'b0, 32'h20, 32'h0,         2'b01, 3'b001, 1'b0, 1'b0, 32'hFFFF_8000};
      vecs[10] = '{1'b1, 1'b1, 32'h30, 32'h1111_1111, 2'b11, 3'b010, 1'b0, 1'b1, 32'hFFFF_8000};
      vecs[11] = '{1'b1, 1'b0, 32'h30, 32'h0,         2'b10, 3'b010, 1'b0, 1'b0, 32'h0000_0000};
      vecs[12] = '{1'b0, 1'b0, 32'h21, 32'h0,         2'b01, 3'b101, 1'b0, 1'b1, 32'h0000_0000};
      vecs[13] = '{1'b0, 1'b1, 32'h32, 32'h0000_A5C3, 2'b01, 3'b001, 1'b1, 1'b0, 32'h0000_0000};
      vecs[14] = '{1'b1, 1'b0, 32'h30, 32'h0,         2'b10, 3'b010, 1'b0, 1'b0, 32'hA5C3_0000};

      // Reset: grants are suppressed even with both requests up
      rst = 1'b1;
      req = 2'b11;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 3'b010);
      @(negedge clk);
      @(negedge clk);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      req = 2'b00;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_rerr", 32'(rerr), 32'd0);
      chk("post_rst_rdata", rdata, 32'd0);
      chk("post_rst_wr", 32'(m_wr_en), 32'd0);
      chk("post_rst_addr", m_addr, 32'd0);
      chk("post_rst_ssize", 32'(m_store_size), 32'd0);

      for (int i = 0; i < int'(NVEC); i++) begin
         run_vec($sformatf("v%0d", i), vecs[i]);
      end

      // Reset during the ACCESS cycle of a store
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 32'h40, 32'hCAFE_F00D, 2'b10, 3'b010);
      req = 2'b01;
      @(negedge clk);
      chk("mid_gnt", 32'(gnt), 32'd1);
      @(posedge clk); #1;
      req = 2'b00;
      @(negedge clk);
      chk("mid_acc_wr", 32'(m_wr_en), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_wr_drop", 32'(m_wr_en), 32'd0);
      chk("mid_addr", m_addr, 32'd0);
      chk("mid_wdata", m_wdata, 32'd0);
      chk("mid_sizes", 32'({m_store_size, m_load_size, m_funct3}), 32'd0);
      chk("mid_gnt0", 32'(gnt), 32'd0);
      chk("mid_rvalid", 32'(rvalid), 32'd0);
      chk("mid_rerr", 32'(rerr), 32'd0);
      chk("mid_rdata", rdata, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_after_rv", 32'(rvalid), 32'd0);
      @(negedge clk);
      chk("mid_after_rv2", 32'(rvalid), 32'd0);
      chk("mid_mem", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'd0);
      lv = '{1'b0, 1'b0, 32'h40, 32'h0, 2'b10, 3'b010, 1'b0, 1'b0, 32'h0};
      run_vec("mid_load", lv);

      // Contention: both requesters hold req for four grants, two cycles apart
      do_reset();
      @(posedge clk); #1;
      we = 2'b00;
      addr0 = 32'h10; addr1 = 32'h20;
      wdata0 = 32'h0; wdata1 = 32'h0;
      size0 = 2'b10; size1 = 2'b10;
      funct3_0 = 3'b010; funct3_1 = 3'b010;
      req = 2'b11;
      n_g = 0;
      cyc = 0;
      while (n_g < 4 && cyc < 20) begin
         @(negedge clk);
         if (gnt != 2'b00) begin
`ifdef DMEM_ARB_RR_EN
            exp_g = n_g[0] ? 2'b10 : 2'b01;
`else
            exp_g = 2'b01;
`endif
            chk($sformatf("cont_gnt%0d", n_g), 32'(gnt), 32'(exp_g));
            chk($sformatf("cont_cyc%0d", n_g), 32'(cyc), 32'(2 * n_g));
            n_g++;
            if (n_g == 4) begin
               @(posedge clk); #1;
               req = 2'b00;
            end
         end
         cyc++;
      end
      chk("cont_grants", 32'(n_g), 32'd4);
      @(negedge clk);
      @(negedge clk);

      // Back-to-back loads from requester 1
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 3'b010);
      req = 2'b10;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         exp_g  = (c % 2 == 0 && c <= 4) ? 2'b10 : 2'b00;
         exp_rv = (c % 2 == 0 && c >= 2) ? 2'b10 : 2'b00;
         chk($sformatf("b2b_gnt_c%0d", c), 32'(gnt), 32'(exp_g));
         chk($sformatf("b2b_rv_c%0d", c), 32'(rvalid), 32'(exp_rv));
         if (c == 4) begin
            @(posedge clk); #1;
            req = 2'b00;
         end
      end
      chk("b2b_rdata", rdata, 32'hDEAD_BEEF);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the shared data memory. It sits between the CPU core's data port (requester 0) and a secondary master such as a program loader or debug port (requester 1), and the `data_memory` port (`d_wr_en`, `dAddr`, `dWdata`, `store_size`, `load_size`, `funct3`, `dRdata`). It serialises one access at a time through an IDLE/ACCESS/DONE state machine, checks alignment, and returns read data and a completion strobe to the winning requester.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width; must be 32.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 2: access request, bit i = requester i; held until `gnt[i]`.
- `we` in 2: 1 = store, 0 = load, per requester.
- `addr0`, `addr1` in AW: byte address.
- `wdata0`, `wdata1` in DW: store data, right-aligned.
- `size0`, `size1` in 2: 00 byte, 01 half, 10 word; 11 illegal.
- `funct3_0`, `funct3_1` in 3: load sign/zero select, passed to memory.
- `gnt` out 2: one-hot accept strobe, one cycle.
- `rvalid` out 2: one-hot completion strobe, one cycle.
- `rerr` out 1: valid with `rvalid`; 1 = misaligned or illegal size, memory untouched.
- `rdata` out DW: load result; holds its value until the next load completion.
- `m_wr_en` out 1, `m_addr` out AW, `m_wdata` out DW, `m_store_size` out 2, `m_load_size` out 2, `m_funct3` out 3: memory side.
- `m_rdata` in DW: combinational read data from memory.

## Operation
- States: IDLE, ACCESS, DONE. Reset state IDLE.
- In IDLE or DONE with `req != 0`: pick a winner, assert `gnt[winner]` combinationally, latch that requester's `we/addr/wdata/size/funct3` and the winner index at the clock edge, then go to ACCESS. With no request, IDLE stays IDLE and DONE goes to IDLE.
- ACCESS (exactly one cycle): drive the memory bus from the latched command. `m_wr_en` = latched `we` AND legal. `m_store_size` and `m_load_size` both equal latched size. At the closing edge the write commits to memory, and for a legal load `m_rdata` is captured into `rdata`. Next state is DONE.
- DONE: `rvalid[winner]` = 1. `rerr` = illegal flag.
- Legal access: size 00 any address; size 01 needs `addr[0] == 0`; size 10 needs `addr[1:0] == 0`; size 11 is never legal. Illegal accesses still go through ACCESS with `m_wr_en = 0`, and `rdata` is unchanged.
- Memory outputs outside ACCESS: `m_wr_en = 0`, all other memory outputs 0.
- Only one `gnt` bit is ever high. A requester must not deassert `req` before its grant.

## Timing
- Reset values: `gnt = 0`, `rvalid = 0`, `rerr = 0`, `rdata = 0`, all `m_*` = 0, last-winner register = 1. Grant logic is gated by `rst`.
- Latency: `gnt` in cycle N, ACCESS in N+1, `rvalid` in N+2.
- Peak throughput is one access per 2 cycles, because a grant issued in DONE overlaps the completion.
- A requester that sees `gnt` in cycle N and keeps `req` high in cycle N+1 is a new request. It is re-arbitrated in DONE (N+2), not in ACCESS.
- Reset asserted mid-ACCESS: `m_wr_en` drops immediately, no write commits, the FSM goes to IDLE, and no `rvalid` is issued.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin. When both requesters are active, the one not recorded as last winner wins, and the last-winner register updates on every grant. Because the register resets to 1, the first contested grant goes to requester 0.
- Undefined: fixed priority. Requester 0 always wins a contest, and the last-winner register is not implemented.

## Test plan
- Single store then load. Requester 0 stores word 0xDEADBEEF at 0x10, then loads word at 0x10. Required: `m_wr_en` high exactly one cycle, `rvalid[0]` two cycles after each `gnt[0]`, `rdata` = 0xDEADBEEF, `rerr` = 0.
- Contention. Both requesters hold `req` for 4 grants. With `DMEM_ARB_RR_EN`: grants alternate 0,1,0,1. Without it: 0,0,0,0 and requester 1 waits.
- Misalignment. Half store at 0x13, then word load at 0x22. Required: `m_wr_en` never high, `rvalid` with `rerr` = 1 for both, memory and `rdata` unchanged.
- Byte and half sizes. Byte store 0x80 at 0x21, then load with `funct3` 100 (LBU) and 000 (LB). Required: `m_store_size`/`m_load_size` = 00 during ACCESS, `rdata` = 0x00000080 and 0xFFFFFF80.
- Back-to-back. Requester 1 holds `req` for 3 loads. Required: grants every 2 cycles, and each `rvalid[1]` coincides with the next `gnt[1]`.
- Reset mid-ACCESS. Assert `rst` during the ACCESS cycle of a store to 0x40. Required: the location is unchanged, all outputs are 0, and the FSM is in IDLE after release.
